sync_fifo_param: RTL and testbench
==================================

# sync_fifo_param

Parametrised synchronous first-word-fall-through FIFO: the general-purpose successor to our 2-entry skid-buffer FIFO, for any power-of-two depth. It adds an occupancy count, registered almost-full/almost-empty flags, a synchronous flush, and an optional mode that accepts a write into a full FIFO when a read completes in the same cycle. It sits between any two valid/ready stages in a single clock domain.

## Interface
- DATA_WIDTH, 8, payload width in bits (≥1).
- FIFO_DEPTH, 4, entry count; power of two, ≥2.
- AF_THRESH, FIFO_DEPTH-1, almost_full_o asserts when count ≥ AF_THRESH; range 1..FIFO_DEPTH.
- AE_THRESH, 1, almost_empty_o asserts when count ≤ AE_THRESH; range 0..FIFO_DEPTH-1.
- FULL_RW, 0, 1 = write accepted while full if a read handshake occurs the same cycle.
- ADDR_WIDTH, $clog2(FIFO_DEPTH), derived; not to be overridden.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- flush_i  in  1  synchronous clear of contents; active high.
- data_i  in  DATA_WIDTH  write data.
- wr_valid_i  in  1  producer offers data_i.
- wr_ready_o  out  1  FIFO can accept a write this cycle.
- data_o  out  DATA_WIDTH  head entry; meaningful only while rd_ready_o=1.
- rd_valid_i  in  1  consumer requests a pop.
- rd_ready_o  out  1  FIFO holds at least one entry.
- count_o  out  ADDR_WIDTH+1  current occupancy, 0..FIFO_DEPTH.
- almost_full_o  out  1  registered threshold flag.
- almost_empty_o  out  1  registered threshold flag.

## Operation
- Storage: FIFO_DEPTH × DATA_WIDTH array, no reset on the array; read and write pointers ADDR_WIDTH+1 bits wide, MSB is the wrap bit.
- Empty: pointers equal. Full: low bits equal and wrap bits differ.
- wr_handshake = wr_valid_i & wr_ready_o; rd_handshake = rd_valid_i & rd_ready_o.
- rd_ready_o = ~empty & ~flush_i.
- wr_ready_o = ~flush_i & (~full | (FULL_RW & rd_valid_i)). With FULL_RW=1 the path rd_valid_i → wr_ready_o is combinational; with FULL_RW=0 wr_ready_o depends on registered state only (plus flush_i).
- On wr_handshake: mem[wr_ptr low bits] ← data_i; wr_ptr +1, wrapping modulo 2·FIFO_DEPTH.
- On rd_handshake: rd_ptr +1, wrapping the same way.
- count register: +1 on write only, −1 on read only, unchanged on both or neither. Count never exceeds FIFO_DEPTH and never drops below 0.
- Flags registered from next count: almost_full_o ← (next_count ≥ AF_THRESH); almost_empty_o ← (next_count ≤ AE_THRESH).
- Flush: pointers and count ← 0, almost_full_o ← 0, almost_empty_o ← 1. Both readies are forced low in the flush cycle, so no handshake is lost or half-applied.
- Reset (rst_n=0) has the same effect as flush and takes priority over it.
- Simultaneous read and write when empty: the read is not possible (rd_ready_o=0); only the write completes.

## Timing
- Reset values: count_o=0, rd_ready_o=0, wr_ready_o=1 once rst_n=1 (0 while flush_i=1), almost_full_o=0, almost_empty_o=1, data_o undefined.
- Write-to-read latency: data written at edge N appears on data_o with rd_ready_o=1 in the cycle after edge N.
- data_o is combinational from the array at rd_ptr (FWFT). It updates in the cycle after a rd_handshake.
- count_o and the flags change on the same edge as the pointers; there is no extra lag.
- Full throughput: one write and one read per cycle are sustained indefinitely, including across pointer wrap.

## Test plan
- Reset, then DEPTH=4, AF=3, AE=1: write 0x11,0x22,0x33,0x44 back-to-back -> count 1,2,3,4; almost_empty_o drops after the 2nd write; almost_full_o rises after the 3rd; wr_ready_o=0 after the 4th; a 5th write of 0x55 is not accepted.
- Drain the full FIFO with rd_valid_i held high -> data_o reads 0x11,0x22,0x33,0x44 on consecutive cycles; rd_ready_o=0 and count 0 afterwards; a read while empty leaves pointers unchanged.
- Full FIFO, FULL_RW=1, wr_valid_i=rd_valid_i=1 with data 0xA5 -> both handshake, count stays 4, and 0xA5 emerges after the three older entries. With FULL_RW=0 the same stimulus gives only the read, and count goes to 3.
- Streaming 3·DEPTH+1 incrementing bytes with simultaneous read/write -> output sequence is exact and in order across pointer wrap; count stays constant.
- Flush asserted with count=3 while wr_valid_i=rd_valid_i=1 -> no handshake that cycle; next cycle count 0, almost_empty_o=1, almost_full_o=0, rd_ready_o=0.
- rst_n pulsed low mid-stream with count=2 -> all outputs return to reset values on the next edge; the first write after release is the first word read out.

Source files
------------

// File: rtl/sync_fifo_param.sv
// Parametrised first-word-fall-through FIFO for a single clock domain.
// Keeps an occupancy count with registered almost-full/almost-empty flags and a synchronous flush.
module sync_fifo_param #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int AF_THRESH  = FIFO_DEPTH - 1,
  parameter int AE_THRESH  = 1,
  parameter bit FULL_RW    = 1'b0,
  parameter int ADDR_WIDTH = $clog2(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  wr_valid_i,
  output logic                  wr_ready_o,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  rd_valid_i,
  output logic                  rd_ready_o,
  output logic [ADDR_WIDTH:0]   count_o,
  output logic                  almost_full_o,
  output logic                  almost_empty_o
);

  localparam logic [ADDR_WIDTH:0] AF_LVL  = AF_THRESH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AE_LVL  = AE_THRESH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [DATA_WIDTH-1:0] mem_r [FIFO_DEPTH];
  logic [ADDR_WIDTH:0]   wr_ptr_r;
  logic [ADDR_WIDTH:0]   rd_ptr_r;
  logic [ADDR_WIDTH:0]   count_r;
  logic                  af_r;
  logic                  ae_r;

  logic                  empty_s;
  logic                  full_s;
  logic                  wr_hs_s;
  logic                  rd_hs_s;
  logic [ADDR_WIDTH:0]   next_count_s;

  // Pointers carry an extra wrap bit so equal low bits can be told apart as empty or full.
  assign empty_s = (wr_ptr_r == rd_ptr_r);
  assign full_s  = (wr_ptr_r[ADDR_WIDTH-1:0] == rd_ptr_r[ADDR_WIDTH-1:0]) &&
                   (wr_ptr_r[ADDR_WIDTH] != rd_ptr_r[ADDR_WIDTH]);

  assign rd_ready_o = ~empty_s & ~flush_i;
  assign wr_ready_o = ~flush_i & (~full_s | (FULL_RW & rd_valid_i));

  assign wr_hs_s = wr_valid_i & wr_ready_o;
  assign rd_hs_s = rd_valid_i & rd_ready_o;

  assign data_o         = mem_r[rd_ptr_r[ADDR_WIDTH-1:0]];
  assign count_o        = count_r;
  assign almost_full_o  = af_r;
  assign almost_empty_o = ae_r;

  // Occupancy after this cycle's handshakes; a simultaneous push and pop cancel out.
  always_comb begin
    next_count_s = count_r;
    case ({wr_hs_s, rd_hs_s})
      2'b10:   next_count_s = count_r + PTR_ONE;
      2'b01:   next_count_s = count_r - PTR_ONE;
      default: next_count_s = count_r;
    endcase
  end

  // Storage array: written on a write handshake, never cleared.
  always_ff @(posedge clk) begin
    if (rst_n && wr_hs_s) begin
      mem_r[wr_ptr_r[ADDR_WIDTH-1:0]] <= data_i;
    end
  end

  // Pointers, count and threshold flags; reset and flush both return to the empty state.
  always_ff @(posedge clk) begin
    if (!rst_n || flush_i) begin
      wr_ptr_r <= {(ADDR_WIDTH+1){1'b0}};
      rd_ptr_r <= {(ADDR_WIDTH+1){1'b0}};
      count_r  <= {(ADDR_WIDTH+1){1'b0}};
      af_r     <= 1'b0;
      ae_r     <= 1'b1;
    end else begin
      if (wr_hs_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (rd_hs_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      count_r <= next_count_s;
      af_r    <= (next_count_s >= AF_LVL);
      ae_r    <= (next_count_s <= AE_LVL);
    end
  end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: two instances (FULL_RW=0 and FULL_RW=1) share stimulus and are
// compared every cycle against queue-based models of the FIFO's behaviour.
module tb_sync_fifo_param;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int AF    = 3;
  localparam int AE    = 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic [DW-1:0] data_in;
  logic          wr_valid;
  logic          rd_valid;

  logic          wrr0, rdr0, af0, ae0;
  logic [DW-1:0] d0;
  logic [2:0]    c0;
  logic          wrr1, rdr1, af1, ae1;
  logic [DW-1:0] d1;
  logic [2:0]    c1;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];

  always #5 clk = ~clk;

  sync_fifo_param #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE), .FULL_RW(1'b0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .flush_i(flush), .data_i(data_in), .wr_valid_i(wr_valid),
    .wr_ready_o(wrr0), .data_o(d0), .rd_valid_i(rd_valid), .rd_ready_o(rdr0), .count_o(c0),
    .almost_full_o(af0), .almost_empty_o(ae0));

  sync_fifo_param #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .AF_THRESH(AF), .AE_THRESH(AE), .FULL_RW(1'b1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .flush_i(flush), .data_i(data_in), .wr_valid_i(wr_valid),
    .wr_ready_o(wrr1), .data_o(d1), .rd_valid_i(rd_valid), .rd_ready_o(rdr1), .count_o(c1),
    .almost_full_o(af1), .almost_empty_o(ae1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Model of one FIFO instance's ready outputs given its occupancy.
  function automatic bit exp_wr_ready(input int sz, input bit frw);
    return !flush && (sz < DEPTH || (frw && rd_valid));
  endfunction

  function automatic bit exp_rd_ready(input int sz);
    return !flush && (sz > 0);
  endfunction

  task automatic check_one(input string n, input bit frw, input int sz, input logic [DW-1:0] head,
                           input logic wr_o, input logic rd_o, input logic [DW-1:0] d,
                           input logic [2:0] c, input logic af, input logic ae);
    chk({n, "_wr_ready"}, 32'(wr_o), 32'(exp_wr_ready(sz, frw)));
    chk({n, "_rd_ready"}, 32'(rd_o), 32'(exp_rd_ready(sz)));
    chk({n, "_count"}, 32'(c), 32'(sz));
    chk({n, "_almost_full"}, 32'(af), 32'(sz >= AF));
    chk({n, "_almost_empty"}, 32'(ae), 32'(sz <= AE));
    if (exp_rd_ready(sz)) chk({n, "_data"}, 32'(d), 32'(head));
  endtask

  // One clock: check outputs against the models, take the edge, then advance the models.
  task automatic cycle();
    bit w0, r0, w1, r1;
    logic [DW-1:0] din;
    #1;
    if (chk_en) begin
      check_one("fifo0", 1'b0, q0.size(), (q0.size() > 0) ? q0[0] : 8'h00, wrr0, rdr0, d0, c0, af0, ae0);
      check_one("fifo1", 1'b1, q1.size(), (q1.size() > 0) ? q1[0] : 8'h00, wrr1, rdr1, d1, c1, af1, ae1);
    end
    w0 = wr_valid && exp_wr_ready(q0.size(), 1'b0);
    r0 = rd_valid && exp_rd_ready(q0.size());
    w1 = wr_valid && exp_wr_ready(q1.size(), 1'b1);
    r1 = rd_valid && exp_rd_ready(q1.size());
    din = data_in;
    @(posedge clk);
    if (!rst_n || flush) begin
      q0.delete();
      q1.delete();
    end else begin
      if (r0) void'(q0.pop_front());
      if (w0) q0.push_back(din);
      if (r1) void'(q1.pop_front());
      if (w1) q1.push_back(din);
    end
    #2;
  endtask

  task automatic drive(input logic w, input logic [DW-1:0] d, input logic r, input logic f);
    wr_valid = w;
    data_in  = d;
    rd_valid = r;
    flush    = f;
    cycle();
  endtask

  initial begin
    logic [DW-1:0] wvals [4];
    wvals[0] = 8'h11; wvals[1] = 8'h22; wvals[2] = 8'h33; wvals[3] = 8'h44;

    rst_n = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    chk_en = 1'b1;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    chk("rst_count", 32'(c0), 32'd0);
    chk("rst_almost_full", 32'(af1), 32'd0);
    chk("rst_almost_empty", 32'(ae1), 32'd1);
    rst_n = 1'b1;

    // Fill to full, then a rejected fifth write.
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, wvals[k], 1'b0, 1'b0);
      chk("fill_count", 32'(c0), 32'(k + 1));
    end
    chk("full_wr_ready", 32'(wrr0), 32'd0);
    drive(1'b1, 8'h55, 1'b0, 1'b0);
    chk("reject_count", 32'(c1), 32'd4);

    // Write while full with a simultaneous read.
    drive(1'b1, 8'hA5, 1'b1, 1'b0);
    chk("fullrw1_count", 32'(c1), 32'd4);
    chk("fullrw0_count", 32'(c0), 32'd3);

    // Drain, then a read while empty.
    for (int k = 0; k < 5; k++) drive(1'b0, 8'h00, 1'b1, 1'b0);
    chk("drained_count", 32'(c1), 32'd0);
    drive(1'b0, 8'h00, 1'b1, 1'b0);
    drive(1'b1, 8'h3C, 1'b0, 1'b0);
    chk("after_empty_read_data", 32'(d0), 32'h3C);

    // Streaming across pointer wrap with constant occupancy.
    drive(1'b1, 8'h00, 1'b0, 1'b0);
    for (int i = 1; i <= 3 * DEPTH + 1; i++) begin
      drive(1'b1, 8'(i), 1'b1, 1'b0);
      chk("stream_count", 32'(c0), 32'd2);
    end

    // Flush at count 3 with both valids high.
    drive(1'b1, 8'h99, 1'b0, 1'b0);
    chk("preflush_count", 32'(c1), 32'd3);
    drive(1'b1, 8'hEE, 1'b1, 1'b1);
    chk("flush_count", 32'(c0), 32'd0);
    chk("flush_almost_empty", 32'(ae0), 32'd1);
    chk("flush_almost_full", 32'(af1), 32'd0);
    drive(1'b0, 8'h00, 1'b0, 1'b0);

    // Reset pulse mid-stream at count 2.
    drive(1'b1, 8'h61, 1'b0, 1'b0);
    drive(1'b1, 8'h62, 1'b0, 1'b0);
    rst_n = 1'b0;
    drive(1'b1, 8'h63, 1'b1, 1'b0);
    chk("midrst_count", 32'(c1), 32'd0);
    chk("midrst_almost_empty", 32'(ae1), 32'd1);
    rst_n = 1'b1;
    drive(1'b1, 8'h77, 1'b0, 1'b0);
    chk("postrst_first_data", 32'(d1), 32'h77);
    drive(1'b0, 8'h00, 1'b1, 1'b0);

    // Randomised traffic with occasional flush and reset.
    for (int n = 0; n < 400; n++) begin
      rst_n = ($urandom_range(0, 49) != 0);
      drive(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 19) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
